branch_target_buffer_sa: RTL

Parametrised set-associative branch target buffer with saturating-counter direction prediction, the next generation of the datapath's direct-mapped BTB. It sits beside the fetch stage: fetch presents the current PC and receives a combinational hit / taken / target prediction. The branch-resolving stage writes back the actual outcome one update per cycle. A multi-cycle flush sequencer invalidates the table on request, for example on context change or a self-modifying-code fence.

---
 rtl/branch_target_buffer_sa.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/branch_target_buffer_sa.sv
// Set-associative branch target buffer with saturating-counter direction prediction.
// Lookup is combinational; updates and the multi-cycle flush sequencer act on the rising edge.
module branch_target_buffer_sa #(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush,
    output logic        busy
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;

    logic                valid_q  [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
    logic [31:0]         target_q [SETS][WAYS];
    logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];
    logic [WAY_W-1:0]    victim_q [SETS];

    logic [IDX_W-1:0]    l_idx;
    logic [TAG_W-1:0]    l_tag;
    logic                l_hit;
    logic [WAY_W-1:0]    l_way;

    logic [IDX_W-1:0]    u_idx;
    logic [TAG_W-1:0]    u_tag;
    logic                u_hit;
    logic [WAY_W-1:0]    u_way;
    logic                u_free;
    logic [WAY_W-1:0]    free_way;
    logic [WAY_W-1:0]    alloc_way;
    logic [CTR_BITS-1:0] ctr_cur;
    logic [CTR_BITS-1:0] ctr_inc;
    logic [CTR_BITS-1:0] ctr_dec;

    logic                unused_low_bits;

    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];

    assign busy  = (state_q == ST_FLUSH);

    // Lowest matching way wins, should duplicates ever appear.
    always_comb begin
        l_hit = 1'b0;
        l_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!l_hit && valid_q[l_idx][WAY_W'(w)] && (tag_q[l_idx][WAY_W'(w)] == l_tag)) begin
                l_hit = 1'b1;
                l_way = WAY_W'(w);
            end
        end
    end

    assign hit         = l_hit && !busy;
    assign pred_taken  = hit && ctr_q[l_idx][l_way][CTR_BITS-1];
    assign pred_target = pred_taken ? target_q[l_idx][l_way] : lookup_pc + 32'd4;

    always_comb begin
        u_hit    = 1'b0;
        u_way    = '0;
        u_free   = 1'b0;
        free_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!u_hit && valid_q[u_idx][WAY_W'(w)] && (tag_q[u_idx][WAY_W'(w)] == u_tag)) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
            if (!u_free && !valid_q[u_idx][WAY_W'(w)]) begin
                u_free   = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    assign alloc_way = u_free ? free_way : victim_q[u_idx];
    assign ctr_cur   = ctr_q[u_idx][u_way];
    assign ctr_inc   = (ctr_cur == '1) ? ctr_cur : ctr_cur + 1'b1;
    assign ctr_dec   = (ctr_cur == '0) ? ctr_cur : ctr_cur - 1'b1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Updates are dropped while flushing; a same-cycle update and flush in IDLE both take effect.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                victim_q[IDX_W'(s)] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[IDX_W'(s)][WAY_W'(w)]  <= 1'b0;
                    tag_q[IDX_W'(s)][WAY_W'(w)]    <= '0;
                    target_q[IDX_W'(s)][WAY_W'(w)] <= '0;
                    ctr_q[IDX_W'(s)][WAY_W'(w)]    <= '0;
                end
            end
        end else if (state_q == ST_FLUSH) begin
            victim_q[cnt_q] <= '0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[cnt_q][WAY_W'(w)] <= 1'b0;
            end
        end else if (upd_en) begin
            if (u_hit) begin
                if (upd_taken) begin
                    ctr_q[u_idx][u_way]    <= ctr_inc;
                    target_q[u_idx][u_way] <= upd_target;
                end else begin
                    ctr_q[u_idx][u_way] <= ctr_dec;
                end
            end else if (upd_taken) begin
                valid_q[u_idx][alloc_way]  <= 1'b1;
                tag_q[u_idx][alloc_way]    <= u_tag;
                target_q[u_idx][alloc_way] <= upd_target;
                ctr_q[u_idx][alloc_way]    <= CTR_WEAK;
                if (!u_free) begin
                    victim_q[u_idx] <= (WAYS == 1) ? '0 : victim_q[u_idx] + 1'b1;
                end
            end
        end
    end

endmodule
